hall_input_conditioner: RTL
===========================

HALL_INPUT_CONDITIONER -- requirements
Module: hall_input_conditioner

Interface
REQ-001 SHALL have parameter FILTER_CYCLES, default 16: consecutive stable synced samples required to accept a new hall code (range 2..255).
REQ-002 SHALL have parameter PERIOD_WIDTH, default 16: width of the commutation period counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port hall_raw  input  3  asynchronous hall sensor pins (h1,h2,h3).
REQ-006 SHALL have port fault_clr  input  1  synchronous one-cycle clear of sticky fault.
REQ-007 SHALL have port hall  output  3  filtered hall code, consumed by the downstream commutation decoder.
REQ-008 SHALL have port hall_valid  output  1  high when hall is one of 001..110.
REQ-009 SHALL have port step  output  1  one-cycle pulse on each legal commutation.
REQ-010 SHALL have port dir  output  1  direction of last legal step (1 = forward).
REQ-011 SHALL have port period  output  PERIOD_WIDTH  clock cycles between last two legal steps.
REQ-012 SHALL have port period_valid  output  1  period holds a genuine measurement.
REQ-013 SHALL have port stall  output  1  no legal step for 2^PERIOD_WIDTH-1 cycles.
REQ-014 SHALL have port fault  output  1  sticky: invalid code or illegal transition seen.

Function
REQ-015 SHALL pass hall_raw through a 2-flop synchronizer (s1, s2) before any other use.
REQ-016 SHALL hold candidate code cand and counter cnt: s2 != cand -> cand <= s2, cnt <= 0; else cnt increments, saturating at FILTER_CYCLES-1.
REQ-017 SHALL load hall <= cand on the edge where cnt == FILTER_CYCLES-1 and cand != hall.
REQ-018 SHALL therefore update hall on the (FILTER_CYCLES+3)th rising edge after a hall_raw change held stable (19 at default); any glitch shorter than FILTER_CYCLES cycles SHALL leave hall unchanged.
REQ-019 SHALL define forward sequence 101 -> 100 -> 110 -> 010 -> 011 -> 001 -> 101; reverse is its inverse.
REQ-020 SHALL, on a hall update from a valid code to its forward/reverse neighbour, assert step for exactly the cycle in which the new hall value first appears and register dir = 1/0 in that same cycle.
REQ-021 SHALL treat valid -> non-adjacent valid as illegal: no step, fault <= 1, period_valid <= 0, dir unchanged.
REQ-022 SHALL, on update to 000 or 111: hall takes the code, hall_valid <= 0, fault <= 1, period_valid <= 0, no step.
REQ-023 SHALL, on update invalid -> valid: hall_valid <= 1, no step, no fault; this code is the new reference for the next step.
REQ-024 SHALL keep tcnt (PERIOD_WIDTH bits): step -> tcnt <= 1; else tcnt increments, saturating at all-ones.
REQ-025 SHALL, on step, load period <= tcnt (steps N cycles apart give period = N) only if a legal step has occurred since the last reset, stall or fault event; otherwise period unchanged, period_valid stays 0 and only the tracking state is armed.
REQ-026 SHALL set period_valid <= 1 whenever period is loaded.
REQ-027 SHALL assert stall while tcnt == all-ones, forcing period_valid <= 0 and disarming (REQ-025); stall deasserts on the next step.
REQ-028 SHALL clear fault on fault_clr unless a new fault event occurs the same cycle (set wins).
REQ-029 SHALL produce no step while hall_valid is 0.

Reset
REQ-030 SHALL, on rst_n low, asynchronously set s1, s2, cand, hall = 000; cnt = 0; hall_valid, step, dir, period_valid, stall, fault = 0; period = 0; tcnt = 1; step tracking disarmed.
REQ-031 SHALL, on rst_n deassert mid-rotation, resume filtering from reset state; first accepted valid code SHALL produce no step and no fault.

Verification
REQ-032 SHALL cover: reset, hall_raw = 101 held -> hall = 101, hall_valid = 1 on edge 19, step = 0, fault = 0.
REQ-033 SHALL cover: stable 101, 10-cycle pulse to 100 then back -> hall stays 101, no step.
REQ-034 SHALL cover: forward rotation, code change every 200 cycles -> step each 200 cycles, dir = 1, first period load at second step, period = 200, period_valid = 1.
REQ-035 SHALL cover: 101 -> 010 jump -> no step, fault = 1, period_valid = 0; fault_clr pulse -> fault = 0.
REQ-036 SHALL cover: hall_raw = 000 -> hall = 000, hall_valid = 0, fault = 1; then PERIOD_WIDTH = 8, hold code 255+ cycles -> stall = 1, period_valid = 0; resume rotation -> stall = 0 on first step.

Source files
------------

// File: rtl/hall_input_conditioner.sv
// Hall sensor front end: synchronizes and debounces the raw hall pins, then derives
// commutation steps, direction, step period, stall and a sticky fault flag.
module hall_input_conditioner #(
    parameter int unsigned FILTER_CYCLES = 16,
    parameter int unsigned PERIOD_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              hall_raw,
    input  logic                    fault_clr,
    output logic [2:0]              hall,
    output logic                    hall_valid,
    output logic                    step,
    output logic                    dir,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_valid,
    output logic                    stall,
    output logic                    fault
);

    localparam int unsigned              CNT_W    = $clog2(FILTER_CYCLES);
    localparam logic [CNT_W-1:0]         CNT_MAX  = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [PERIOD_WIDTH-1:0]  TCNT_MAX = '1;
    localparam logic [PERIOD_WIDTH-1:0]  TCNT_ONE = PERIOD_WIDTH'(1);

    // Forward commutation order: 101 -> 100 -> 110 -> 010 -> 011 -> 001 -> 101
    function automatic logic [2:0] fwd_next(input logic [2:0] code);
        case (code)
            3'b101:  fwd_next = 3'b100;
            3'b100:  fwd_next = 3'b110;
            3'b110:  fwd_next = 3'b010;
            3'b010:  fwd_next = 3'b011;
            3'b011:  fwd_next = 3'b001;
            3'b001:  fwd_next = 3'b101;
            default: fwd_next = 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] rev_next(input logic [2:0] code);
        case (code)
            3'b100:  rev_next = 3'b101;
            3'b110:  rev_next = 3'b100;
            3'b010:  rev_next = 3'b110;
            3'b011:  rev_next = 3'b010;
            3'b001:  rev_next = 3'b011;
            3'b101:  rev_next = 3'b001;
            default: rev_next = 3'b000;
        endcase
    endfunction

    logic [2:0]              r_s1;
    logic [2:0]              r_s2;
    logic [2:0]              r_cand;
    logic [CNT_W-1:0]        r_cnt;
    logic [2:0]              r_hall;
    logic                    r_hall_valid;
    logic                    r_step;
    logic                    r_dir;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic                    r_period_valid;
    logic                    r_stall;
    logic                    r_fault;
    logic [PERIOD_WIDTH-1:0] r_tcnt;
    logic                    r_armed;

    logic                    w_load;
    logic                    w_new_valid;
    logic                    w_is_fwd;
    logic                    w_is_rev;
    logic                    w_step;
    logic                    w_fault_evt;
    logic [PERIOD_WIDTH-1:0] w_tcnt_next;
    logic                    w_stall_evt;

    // Classify the pending hall update against the currently accepted code
    always_comb begin
        w_load      = (r_cnt == CNT_MAX) && (r_cand != r_hall);
        w_new_valid = (r_cand != 3'b000) && (r_cand != 3'b111);
        w_is_fwd    = r_hall_valid && (fwd_next(r_hall) == r_cand);
        w_is_rev    = r_hall_valid && (rev_next(r_hall) == r_cand);
        w_step      = w_load && w_new_valid && (w_is_fwd || w_is_rev);
        w_fault_evt = w_load && (!w_new_valid || (r_hall_valid && !w_is_fwd && !w_is_rev));
        w_tcnt_next = w_step ? TCNT_ONE
                    : ((r_tcnt == TCNT_MAX) ? r_tcnt : r_tcnt + TCNT_ONE);
        w_stall_evt = (w_tcnt_next == TCNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1           <= 3'b000;
            r_s2           <= 3'b000;
            r_cand         <= 3'b000;
            r_cnt          <= '0;
            r_hall         <= 3'b000;
            r_hall_valid   <= 1'b0;
            r_step         <= 1'b0;
            r_dir          <= 1'b0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_stall        <= 1'b0;
            r_fault        <= 1'b0;
            r_tcnt         <= TCNT_ONE;
            r_armed        <= 1'b0;
        end else begin
            r_s1 <= hall_raw;
            r_s2 <= r_s1;

            // Debounce: candidate must hold for FILTER_CYCLES samples before acceptance
            if (r_s2 != r_cand) begin
                r_cand <= r_s2;
                r_cnt  <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end

            if (w_load) begin
                r_hall       <= r_cand;
                r_hall_valid <= w_new_valid;
            end

            r_step <= w_step;
            if (w_step) begin
                r_dir <= w_is_fwd;
            end

            r_tcnt  <= w_tcnt_next;
            r_stall <= w_stall_evt;

            // A period is only trusted once two consecutive legal steps bracket it
            if (w_fault_evt || w_stall_evt) begin
                r_period_valid <= 1'b0;
                r_armed        <= 1'b0;
            end else if (w_step) begin
                if (r_armed) begin
                    r_period       <= r_tcnt;
                    r_period_valid <= 1'b1;
                end
                r_armed <= 1'b1;
            end

            r_fault <= w_fault_evt || (r_fault && !fault_clr);
        end
    end

    assign hall         = r_hall;
    assign hall_valid   = r_hall_valid;
    assign step         = r_step;
    assign dir          = r_dir;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign stall        = r_stall;
    assign fault        = r_fault;

endmodule
